// File: rtl/id_pkg.sv
// Shared types and defaults for the decode-stage register file and its scoreboard.
package id_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;
    localparam int AW_DEFAULT   = $clog2(NREG_DEFAULT);

    typedef logic [AW_DEFAULT-1:0]   regaddr_t;
    typedef logic [XLEN_DEFAULT-1:0] word_t;

    localparam regaddr_t REG_ZERO = '0;

endpackage

// File: rtl/id_sb_bits.sv
// Pending scoreboard: one bit per register owned by an outstanding long-latency writer,
// plus the source/WAW hazard detection that turns it into a decode stall.
module id_sb_bits #(
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG),
    parameter int NRD  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rs_addr,
    input  logic [NRD-1:0]    rs_used,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    input  logic              issue_long,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_rd,
    output logic              stall,
    output logic [AW:0]       pend_cnt
);

    logic [NREG-1:0] pending_q, pending_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            src_haz;
    logic            waw_haz;
    logic [AW-1:0]   addr;

    // A writeback landing this cycle is forwarded by the bypass, so it cancels the hazard.
    always_comb begin
        src_haz = 1'b0;
        addr    = '0;
        for (int i = 0; i < NRD; i++) begin
            addr = rs_addr[i*AW +: AW];
            if (rs_used[i] && pending_q[addr] && !(wb_valid && wb_rd == addr)) begin
                src_haz = 1'b1;
            end
        end
    end

    always_comb begin
        waw_haz = issue_long && (issue_rd != '0) && pending_q[issue_rd]
                  && !(wb_valid && wb_rd == issue_rd);
    end

    assign stall = src_haz || waw_haz;

    // Set is applied after clear so a new long-latency writer keeps ownership.
    always_comb begin
        pending_d = pending_q;
        if (wb_valid && wb_rd != '0) begin
            pending_d[wb_rd] = 1'b0;
        end
        if (issue_valid && issue_long && issue_rd != '0 && !stall) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + (AW+1)'(pending_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pend_cnt = cnt_q;

endmodule

// File: rtl/id_regfile_sb.sv
// Decode-stage register file: NRD combinational read ports with writeback bypass,
// one write port, and a pending scoreboard that raises stall on unresolved sources.
module id_regfile_sb
    import id_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT,
    parameter int AW   = $clog2(NREG),
    parameter int NRD  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs_addr,
    input  logic [NRD-1:0]      rs_used,
    output logic [NRD*XLEN-1:0] rs_data,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    input  logic                issue_long,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    output logic                stall,
    output logic [AW:0]         pend_cnt
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [AW-1:0]   rd_addr [NRD];

    always_comb begin
        regs_d = regs_q;
        if (wb_valid && wb_rd != '0) begin
            regs_d[wb_rd] = wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_addr[i] = rs_addr[i*AW +: AW];
        end
    end

    // Outputs are forced to zero while reset is held, even if a writeback is presented.
    always_comb begin
        rs_data = '0;
        for (int i = 0; i < NRD; i++) begin
            if (rst || rd_addr[i] == '0) begin
                rs_data[i*XLEN +: XLEN] = '0;
            end else if (wb_valid && wb_rd == rd_addr[i]) begin
                rs_data[i*XLEN +: XLEN] = wb_data;
            end else begin
                rs_data[i*XLEN +: XLEN] = regs_q[rd_addr[i]];
            end
        end
    end

    id_sb_bits #(
        .NREG (NREG),
        .AW   (AW),
        .NRD  (NRD)
    ) u_sb_bits (
        .clk         (clk),
        .rst         (rst),
        .rs_addr     (rs_addr),
        .rs_used     (rs_used),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_long  (issue_long),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .stall       (stall),
        .pend_cnt    (pend_cnt)
    );

endmodule

// File: tb/tb_id_regfile_sb.sv
// Directed bench for id_regfile_sb: read/write/bypass, scoreboard stall, WAW, async reset.
module tb_id_regfile_sb;
    import id_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;

    logic                clk;
    logic                rst;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD-1:0]      rs_used;
    logic [NRD*XLEN-1:0] rs_data;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic                issue_long;
    logic                wb_valid;
    logic [AW-1:0]       wb_rd;
    logic [XLEN-1:0]     wb_data;
    logic                stall;
    logic [AW:0]         pend_cnt;

    int checks = 0;
    int errors = 0;

    id_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk         (clk),
        .rst         (rst),
        .rs_addr     (rs_addr),
        .rs_used     (rs_used),
        .rs_data     (rs_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_long  (issue_long),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .stall       (stall),
        .pend_cnt    (pend_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // advance past the next rising edge; inputs change and checks happen away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a);
        rs_addr[p*AW +: AW] = a;
    endtask

    function automatic logic [XLEN-1:0] port_data(input int p);
        return rs_data[p*XLEN +: XLEN];
    endfunction

    task automatic drive_idle();
        issue_valid = 1'b0;
        issue_rd    = '0;
        issue_long  = 1'b0;
        wb_valid    = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        rs_used     = '0;
    endtask

    task automatic issue_long_op(input logic [AW-1:0] rd);
        issue_valid = 1'b1;
        issue_long  = 1'b1;
        issue_rd    = rd;
        tick();
        issue_valid = 1'b0;
        issue_long  = 1'b0;
        issue_rd    = '0;
    endtask

    task automatic writeback(input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_data  = d;
        tick();
        wb_valid = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
    endtask

    initial begin
        rst     = 1'b1;
        rs_addr = '0;
        drive_idle();
        #1;
        check_eq("rst_pend_cnt", 64'(pend_cnt), 64'd0);
        check_eq("rst_stall", 64'(stall), 64'd0);
        tick();
        tick();
        rst = 1'b0;

        // 1: everything reads zero after reset
        for (int a = 0; a < NREG; a++) begin
            set_port(0, AW'(a));
            set_port(1, AW'(NREG - 1 - a));
            #1;
            check_eq($sformatf("t1_p0_r%0d", a), 64'(port_data(0)), 64'd0);
            check_eq($sformatf("t1_p1_r%0d", NREG - 1 - a), 64'(port_data(1)), 64'd0);
        end
        rs_used = 2'b11;
        #1;
        check_eq("t1_stall", 64'(stall), 64'd0);
        check_eq("t1_pend_cnt", 64'(pend_cnt), 64'd0);
        rs_used = '0;

        // 2: write, bypass, register 0 stays zero
        set_port(0, 5);
        wb_valid = 1'b1; wb_rd = 5; wb_data = 32'hDEADBEEF;
        #1;
        check_eq("t2_bypass", 64'(port_data(0)), 64'hDEADBEEF);
        tick();
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        #1;
        check_eq("t2_stored", 64'(port_data(0)), 64'hDEADBEEF);
        set_port(0, 0);
        wb_valid = 1'b1; wb_rd = 0; wb_data = 32'h1234;
        #1;
        check_eq("t2_r0_bypass", 64'(port_data(0)), 64'd0);
        tick();
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        #1;
        check_eq("t2_r0_stored", 64'(port_data(0)), 64'd0);
        check_eq("t2_pend_cnt", 64'(pend_cnt), 64'd0);

        // 3: long-latency writer to r7, source hazard, resolved by same-cycle writeback
        issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 7;
        #1;
        check_eq("t3_issue_nostall", 64'(stall), 64'd0);
        tick();
        issue_valid = 1'b0; issue_long = 1'b0; issue_rd = '0;
        set_port(1, 7);
        rs_used = 2'b10;
        #1;
        check_eq("t3_stall", 64'(stall), 64'd1);
        check_eq("t3_pend_cnt", 64'(pend_cnt), 64'd1);
        wb_valid = 1'b1; wb_rd = 7; wb_data = 32'h55;
        #1;
        check_eq("t3_wb_stall", 64'(stall), 64'd0);
        check_eq("t3_wb_bypass", 64'(port_data(1)), 64'h55);
        tick();
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        #1;
        check_eq("t3_pend_cleared", 64'(pend_cnt), 64'd0);
        check_eq("t3_stall_after", 64'(stall), 64'd0);
        check_eq("t3_stored", 64'(port_data(1)), 64'h55);

        // 4: pending source that is not consumed does not stall
        issue_long_op(7);
        rs_used = 2'b00;
        set_port(1, 7);
        #1;
        check_eq("t4_unused_stall", 64'(stall), 64'd0);
        check_eq("t4_pend_cnt", 64'(pend_cnt), 64'd1);
        rs_used = 2'b10;
        #1;
        check_eq("t4_used_stall", 64'(stall), 64'd1);
        rs_used = '0;
        writeback(7, 32'h66);
        #1;
        check_eq("t4_pend_clear", 64'(pend_cnt), 64'd0);

        // 5: WAW hazard, suppressed issue, set-wins on simultaneous set/clear
        issue_long_op(9);
        #1;
        check_eq("t5_pend_one", 64'(pend_cnt), 64'd1);
        issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 9;
        #1;
        check_eq("t5_waw_stall", 64'(stall), 64'd1);
        tick();
        check_eq("t5_waw_pend", 64'(pend_cnt), 64'd1);
        // stalled issue to a different register must not set its bit
        issue_rd = 10; issue_long = 1'b1;
        set_port(0, 9);
        rs_used = 2'b01;
        #1;
        check_eq("t5_src_stall", 64'(stall), 64'd1);
        tick();
        check_eq("t5_suppressed", 64'(pend_cnt), 64'd1);
        rs_used = '0;
        issue_rd = 9;
        wb_valid = 1'b1; wb_rd = 9; wb_data = 32'h99;
        #1;
        check_eq("t5_waw_resolved", 64'(stall), 64'd0);
        tick();
        drive_idle();
        #1;
        check_eq("t5_set_wins_cnt", 64'(pend_cnt), 64'd1);
        rs_used = 2'b01;
        #1;
        check_eq("t5_set_wins_bit", 64'(stall), 64'd1);
        rs_used = '0;
        writeback(9, 32'h9A);
        #1;
        check_eq("t5_clear", 64'(pend_cnt), 64'd0);

        // 6: asynchronous reset mid-cycle clears pending and storage
        writeback(4, 32'h77);
        issue_long_op(3);
        issue_long_op(4);
        issue_long_op(6);
        #1;
        check_eq("t6_pend_three", 64'(pend_cnt), 64'd3);
        set_port(0, 4);
        set_port(1, 5);
        #1;
        check_eq("t6_r4_before", 64'(port_data(0)), 64'h77);
        #1;
        rst = 1'b1;
        #1;
        check_eq("t6_async_pend", 64'(pend_cnt), 64'd0);
        check_eq("t6_async_data", 64'(port_data(0)), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check_eq("t6_r4_cleared", 64'(port_data(0)), 64'd0);
        check_eq("t6_r5_cleared", 64'(port_data(1)), 64'd0);
        rs_used = 2'b11;
        set_port(1, 6);
        #1;
        check_eq("t6_no_stall", 64'(stall), 64'd0);
        rs_used = '0;
        writeback(4, 32'hA);
        #1;
        check_eq("t6_r4_written", 64'(port_data(0)), 64'hA);
        check_eq("t6_pend_zero", 64'(pend_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_regfile_sb.md
Name: id_regfile_sb

Overview:
Parametrised decode-stage register file that succeeds the fixed 2-read, 32x32 ID register file. It adds N read ports, same-cycle writeback-to-read bypass and a per-register pending scoreboard for long-latency writers (loads, multi-cycle ops). From the scoreboard it produces a decode stall. It sits between IF/ID and ID/EX. Jump-target arithmetic stays outside this block.

Parameters:
XLEN, 32, data width of every architectural register.
NREG, 32, number of architectural registers; must be a power of two, and register 0 is hardwired to zero.
AW, $clog2(NREG), register address width (derived; do not override).
NRD, 2, number of combinational read ports (1..4).

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  reset, asynchronous, active-high.
rs_addr  in  NRD*AW  source register address for each read port; port i is bits [i*AW +: AW].
rs_used  in  NRD  port i's source is consumed by the instruction in decode; only used ports can stall.
rs_data  out  NRD*XLEN  read data for each port.
issue_valid  in  1  the decode instruction advances to EX this cycle (the caller gates it with !stall).
issue_rd  in  AW  destination register of the issuing instruction.
issue_long  in  1  the issuing instruction's result arrives via wb_* after more than one cycle.
wb_valid  in  1  writeback write enable.
wb_rd  in  AW  writeback destination.
wb_data  in  XLEN  writeback data.
stall  out  1  decode must hold this cycle.
pend_cnt  out  AW+1  number of pending bits currently set.

Behaviour:
- Storage: NREG x XLEN flops plus a pending[NREG] bit vector. On rst, all registers and all pending bits are 0. Outputs during reset: rs_data = 0, stall = 0, pend_cnt = 0.
- Write: on the rising edge of clk, if wb_valid and wb_rd != 0, then reg[wb_rd] <= wb_data. Writes to register 0 are dropped.
- Read (combinational, zero latency), for each port i:
  - rs_addr == 0 gives 0.
  - Otherwise, if wb_valid and wb_rd == rs_addr, the port returns wb_data (write-through bypass).
  - Otherwise the port returns reg[rs_addr].
- Pending set: on a clock edge, pending[issue_rd] <= 1 when issue_valid && issue_long && issue_rd != 0 && !stall.
- Pending clear: on a clock edge, pending[wb_rd] <= 0 when wb_valid && wb_rd != 0.
- Same register set and cleared on the same edge: set wins. The new long-latency writer owns the register.
- pending[0] is never set.
- A source hazard on port i exists when rs_used[i] && pending[rs_addr_i] && !(wb_valid && wb_rd == rs_addr_i). A writeback arriving in the same cycle resolves the hazard via the bypass.
- A WAW hazard exists when issue_long && issue_rd != 0 && pending[issue_rd] && !(wb_valid && wb_rd == issue_rd).
- stall = OR of all source hazards and the WAW hazard. stall is purely combinational and has no registered component.
- If issue_valid is asserted while stall = 1, the pending update is suppressed. The issue is treated as not happening.
- pend_cnt is the registered popcount of pending, so it follows pending with zero extra latency (it updates on the same edge).
- Reset asserted mid-operation: contents and pending bits clear immediately (async). Any outstanding writebacks then write normally but find no pending bit to clear, which is harmless.
- No two writebacks per cycle. A single write port is required.

Decomposition:
- Package id_pkg: XLEN and NREG defaults, the regaddr_t typedef (logic [AW-1:0]), the word_t typedef, and the constant REG_ZERO = '0.
- One natural sub-module, id_sb_bits. It holds the pending vector, its set/clear logic, the hazard compare and the popcount. The storage array and bypass muxes stay in the top level.

Test Plan:
1. Reset, then read all NREG addresses on every port -> all 0. stall = 0, pend_cnt = 0.
2. Write reg 5 = 0xDEADBEEF with wb_valid. On the same cycle rs_addr0 = 5 -> rs_data0 = 0xDEADBEEF (bypass). The next cycle, with no wb, it still reads 0xDEADBEEF. Writing reg 0 = 0x1234 -> reads of reg 0 return 0.
3. Issue a long-latency instruction with rd = 7. Next cycle, rs_addr1 = 7 with rs_used[1] = 1 -> stall = 1, pend_cnt = 1. Then wb to 7 with 0x55 -> stall = 0 in that cycle and rs_data1 = 0x55. pend_cnt reads 0 after the edge.
4. Pending on 7, but rs_used[1] = 0 with rs_addr1 = 7 -> stall = 0.
5. WAW: pending on 9, issue a long-latency instruction with rd = 9 -> stall = 1 and pending unchanged. Then wb to 9 while the same issue is presented -> stall = 0, and after the edge pending[9] = 1 (set wins), pend_cnt = 1.
6. Set pending on 3, 4 and 6 (pend_cnt = 3). Assert rst asynchronously mid-cycle -> pending and registers clear immediately, pend_cnt = 0. A later wb to 4 with 0xA writes the value and reads back 0xA.
